// File: rtl/i2c_pkg.sv
// Shared definitions for the two-requester I2C receive arbiter: FSM states,
// default timing parameters and a small index-to-one-hot helper.
package i2c_pkg;

    localparam int DEF_TIMEOUT_CYC = 4096;
    localparam int DEF_GAP_CYC     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } rx_state_e;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/i2c_rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to the
// index that did not win last time.
module i2c_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = req[gi] & (~req[1-gi] | (last_grant != 1'(gi)));
        end
    endgenerate

endmodule

// File: rtl/i2c_rx_arbiter.sv
// Grants one of two requesters access to an i2c_receive engine, forwards the
// received bytes to the owner and closes each transfer with done or timeout.
module i2c_rx_arbiter
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    input  logic [3:0] req_bytes0,
    input  logic [3:0] req_bytes1,
    output logic [1:0] req_ready,
    output logic [7:0] rx_data,
    output logic [1:0] rx_valid,
    output logic [1:0] done,
    output logic [1:0] timeout_err,
    output logic       busy,
    output logic       i2c_ready,
    output logic [3:0] i2c_data_bytes,
    input  logic [7:0] i2c_data,
    input  logic       i2c_data_valid
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC - 1);

    rx_state_e     state_reg, state_next;
    logic          owner_reg, owner_next;
    logic          last_grant_reg, last_grant_next;
    logic [3:0]    bytes_reg, bytes_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
    logic          dv_reg;
    logic [1:0]    req_ready_reg, req_ready_next;
    logic [7:0]    rx_data_reg, rx_data_next;
    logic [1:0]    rx_valid_reg, rx_valid_next;
    logic [1:0]    done_reg, done_next;
    logic [1:0]    timeout_reg, timeout_next;
    logic          busy_reg, busy_next;
    logic          i2c_ready_reg, i2c_ready_next;

    logic [1:0]    arb_grant;
    logic          byte_edge;
    logic [3:0]    cnt_inc;

    i2c_rr_arb2 u_arb (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .grant      (arb_grant)
    );

    // The edge register tracks the strobe in every state, so a strobe already
    // high when a transfer starts is not mistaken for a new byte.
    assign byte_edge = i2c_data_valid & ~dv_reg;
    assign cnt_inc   = cnt_reg + 4'd1;

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        bytes_next      = bytes_reg;
        cnt_next        = cnt_reg;
        tmo_cnt_next    = tmo_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        i2c_ready_next  = i2c_ready_reg;
        rx_data_next    = rx_data_reg;
        req_ready_next  = '0;
        rx_valid_next   = '0;
        done_next       = '0;
        timeout_next    = '0;
        case (state_reg)
            ST_IDLE: begin
                if (|req_valid) begin
                    owner_next      = arb_grant[1];
                    last_grant_next = arb_grant[1];
                    bytes_next      = arb_grant[1] ? req_bytes1 : req_bytes0;
                    cnt_next        = '0;
                    tmo_cnt_next    = '0;
                    req_ready_next  = arb_grant;
                    i2c_ready_next  = (bytes_next != 4'd0);
                    state_next      = ST_XFER;
                end
            end
            ST_XFER: begin
                // Zero-length requests only spend one cycle here to emit done.
                if (bytes_reg == 4'd0) begin
                    done_next  = onehot2(owner_reg);
                    state_next = ST_IDLE;
                end else if (byte_edge) begin
                    rx_data_next  = i2c_data;
                    rx_valid_next = onehot2(owner_reg);
                    cnt_next      = cnt_inc;
                    tmo_cnt_next  = '0;
                    if (cnt_inc == bytes_reg) begin
                        done_next      = onehot2(owner_reg);
                        i2c_ready_next = 1'b0;
                        gap_cnt_next   = '0;
                        state_next     = ST_GAP;
                    end
                end else if (tmo_cnt_reg == T_LAST) begin
                    timeout_next   = onehot2(owner_reg);
                    i2c_ready_next = 1'b0;
                    gap_cnt_next   = '0;
                    state_next     = ST_GAP;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == G_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            bytes_reg      <= '0;
            cnt_reg        <= '0;
            tmo_cnt_reg    <= '0;
            gap_cnt_reg    <= '0;
            dv_reg         <= 1'b0;
            req_ready_reg  <= '0;
            rx_data_reg    <= '0;
            rx_valid_reg   <= '0;
            done_reg       <= '0;
            timeout_reg    <= '0;
            busy_reg       <= 1'b0;
            i2c_ready_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            bytes_reg      <= bytes_next;
            cnt_reg        <= cnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            dv_reg         <= i2c_data_valid;
            req_ready_reg  <= req_ready_next;
            rx_data_reg    <= rx_data_next;
            rx_valid_reg   <= rx_valid_next;
            done_reg       <= done_next;
            timeout_reg    <= timeout_next;
            busy_reg       <= busy_next;
            i2c_ready_reg  <= i2c_ready_next;
        end
    end

    assign req_ready      = req_ready_reg;
    assign rx_data        = rx_data_reg;
    assign rx_valid       = rx_valid_reg;
    assign done           = done_reg;
    assign timeout_err    = timeout_reg;
    assign busy           = busy_reg;
    assign i2c_ready      = i2c_ready_reg;
    assign i2c_data_bytes = bytes_reg;

endmodule

// File: tb/tb_i2c_rx_arbiter.sv
// Randomised bench for i2c_rx_arbiter: a cycle-level behavioural model checked
// every cycle, plus directed scenarios pinned with hand-computed expectations.
module tb_i2c_rx_arbiter;

    localparam int TO  = 64;
    localparam int GAP = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [3:0] req_bytes0, req_bytes1;
    logic [1:0] req_ready, rx_valid, done, timeout_err;
    logic [7:0] rx_data, i2c_data;
    logic       busy, i2c_ready, i2c_data_valid;
    logic [3:0] i2c_data_bytes;

    i2c_rx_arbiter #(.TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_bytes0     (req_bytes0),
        .req_bytes1     (req_bytes1),
        .req_ready      (req_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .done           (done),
        .timeout_err    (timeout_err),
        .busy           (busy),
        .i2c_ready      (i2c_ready),
        .i2c_data_bytes (i2c_data_bytes),
        .i2c_data       (i2c_data),
        .i2c_data_valid (i2c_data_valid)
    );

    always #5 clk = ~clk;

    int cmp_n = 0;
    int mis_n = 0;

    // stimulus controls, written only by the main sequence
    int   pend0[$], pend1[$];
    bit   req_rand = 0, noise_en = 0;
    int   slave_hold = 1, slave_gap = 1, slave_limit = 15;
    logic [7:0] slave_base = 8'hF0;

    // ---------------- behavioural reference model ----------------
    int   m_phase, m_owner, m_need, m_got, m_quiet, m_gap_left, m_last;
    bit   m_prev_dv, m_edge;
    logic [1:0] e_req_ready, e_rx_valid, e_done, e_tmo;
    logic       e_busy, e_i2c_ready;
    logic [7:0] e_rx_data;
    logic [3:0] e_bytes;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_owner = 0; m_need = 0; m_got = 0; m_quiet = 0;
            m_gap_left = 0; m_last = 1; m_prev_dv = 0;
            e_req_ready = 0; e_rx_valid = 0; e_done = 0; e_tmo = 0;
            e_busy = 0; e_i2c_ready = 0; e_rx_data = 0; e_bytes = 0;
        end else begin
            e_req_ready = 0; e_rx_valid = 0; e_done = 0; e_tmo = 0;
            m_edge = i2c_data_valid && !m_prev_dv;
            m_prev_dv = i2c_data_valid;
            case (m_phase)
                0: if (req_valid != 2'b00) begin
                    if (req_valid == 2'b11) m_owner = 1 - m_last;
                    else m_owner = req_valid[1] ? 1 : 0;
                    m_last = m_owner;
                    m_need = m_owner == 1 ? int'(req_bytes1) : int'(req_bytes0);
                    m_got = 0; m_quiet = 0;
                    e_req_ready = 2'(1 << m_owner);
                    e_bytes = 4'(m_need);
                    e_i2c_ready = (m_need != 0);
                    m_phase = 1;
                end
                1: if (m_need == 0) begin
                    e_done = 2'(1 << m_owner);
                    m_phase = 0;
                end else if (m_edge) begin
                    m_got++; m_quiet = 0;
                    e_rx_valid = 2'(1 << m_owner);
                    e_rx_data = i2c_data;
                    if (m_got == m_need) begin
                        e_done = 2'(1 << m_owner);
                        e_i2c_ready = 0; m_phase = 2; m_gap_left = GAP;
                    end
                end else if (m_quiet == TO - 1) begin
                    e_tmo = 2'(1 << m_owner);
                    e_i2c_ready = 0; m_phase = 2; m_gap_left = GAP;
                end else begin
                    m_quiet++;
                end
                default: begin
                    m_gap_left--;
                    if (m_gap_left == 0) m_phase = 0;
                end
            endcase
            e_busy = (m_phase != 0);
        end
    end

    // ---------------- compare process and event monitor ----------------
    int cyc = 0, i2c_hi = 0;
    int rx_cnt[2], done_cnt[2], tmo_cnt[2], t_rx[2], t_done[2], t_tmo[2], t_rr[2];
    bit done_busy[2], tmo_i2c[2];
    int grants[$];
    logic [7:0] rx_hist0[$];

    always @(negedge clk) begin
        cyc++;
        cmp_n++;
        if ({req_ready, rx_valid, done, timeout_err, busy, i2c_ready} !==
            {e_req_ready, e_rx_valid, e_done, e_tmo, e_busy, e_i2c_ready}) begin
            mis_n++;
            $display("FAIL ctrl cyc=%0d: got rr=%b rv=%b dn=%b to=%b busy=%b rdy=%b, required rr=%b rv=%b dn=%b to=%b busy=%b rdy=%b",
                     cyc, req_ready, rx_valid, done, timeout_err, busy, i2c_ready,
                     e_req_ready, e_rx_valid, e_done, e_tmo, e_busy, e_i2c_ready);
        end
        if (!rst_n || e_i2c_ready) begin
            cmp_n++;
            if (i2c_data_bytes !== e_bytes) begin
                mis_n++;
                $display("FAIL i2c_data_bytes cyc=%0d: got %h, required %h", cyc, i2c_data_bytes, e_bytes);
            end
        end
        if (!rst_n || e_rx_valid != 2'b00) begin
            cmp_n++;
            if (rx_data !== e_rx_data) begin
                mis_n++;
                $display("FAIL rx_data cyc=%0d: got %h, required %h", cyc, rx_data, e_rx_data);
            end
        end
        if (i2c_ready) i2c_hi++;
        for (int n = 0; n < 2; n++) begin
            if (rx_valid[n]) begin
                rx_cnt[n]++; t_rx[n] = cyc;
                if (n == 0) rx_hist0.push_back(rx_data);
            end
            if (done[n]) begin done_cnt[n]++; t_done[n] = cyc; done_busy[n] = busy; end
            if (timeout_err[n]) begin tmo_cnt[n]++; t_tmo[n] = cyc; tmo_i2c[n] = i2c_ready; end
            if (req_ready[n]) begin grants.push_back(n); t_rr[n] = cyc; end
        end
    end

    // ---------------- requesters: hold request until req_ready ----------------
    initial begin
        req_valid = 2'b00; req_bytes0 = 4'h0; req_bytes1 = 4'h0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                req_valid = 2'b00;
            end else begin
                if (req_valid[0] && req_ready[0]) begin
                    req_valid[0] = 1'b0; req_bytes0 = 4'($urandom);
                end else if (!req_valid[0] && pend0.size() > 0 && (!req_rand || $urandom_range(0, 3) == 0)) begin
                    req_bytes0 = 4'(pend0.pop_front()); req_valid[0] = 1'b1;
                end
                if (req_valid[1] && req_ready[1]) begin
                    req_valid[1] = 1'b0; req_bytes1 = 4'($urandom);
                end else if (!req_valid[1] && pend1.size() > 0 && (!req_rand || $urandom_range(0, 3) == 0)) begin
                    req_bytes1 = 4'(pend1.pop_front()); req_valid[1] = 1'b1;
                end
            end
        end
    end

    // ---------------- i2c_receive stand-in ----------------
    int sent = 0;
    initial begin
        i2c_data_valid = 1'b0; i2c_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (!i2c_ready) begin
                sent = 0;
                if (noise_en) begin
                    i2c_data_valid = ($urandom_range(0, 2) == 0);
                    i2c_data = 8'($urandom);
                end else begin
                    i2c_data_valid = 1'b0;
                end
            end else if (i2c_data_valid) begin
                i2c_data_valid = 1'b0;
            end else if (sent < slave_limit) begin
                i2c_data = slave_base + 8'(sent);
                i2c_data_valid = 1'b1;
                sent++;
                repeat (slave_hold) begin
                    @(posedge clk); #1;
                    i2c_data = 8'($urandom);
                end
                i2c_data_valid = 1'b0;
                repeat (slave_gap - 1) begin @(posedge clk); #1; end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        cmp_n++;
        if (act != exp) begin
            mis_n++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic bound_ok(input string name, input bit ok);
        cmp_n++;
        if (!ok) begin
            mis_n++;
            $display("FAIL %s: wait expired, got no event, required event", name);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 2000 && (busy || req_valid != 2'b00); i++) @(posedge clk);
        bound_ok(name, !busy && req_valid == 2'b00);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    int rc, dc, tc, hi0;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", int'({req_ready, rx_valid, done, timeout_err, busy, i2c_ready}), 0);
        chk("reset_rx_data", int'(rx_data), 0);
        chk("reset_bytes", int'(i2c_data_bytes), 0);
        rst_n = 1'b1;

        // simultaneous requests after reset; 7-byte stream F0..F6 to requester 0
        @(posedge clk);
        pend0.push_back(7);
        pend1.push_back(2);
        for (int i = 0; i < 400 && done_cnt[0] < 1; i++) @(posedge clk);
        bound_ok("wait_done0", done_cnt[0] >= 1);
        slave_hold = 4;
        chk("rx_count_7", rx_cnt[0], 7);
        for (int i = 0; i < 7 && i < rx_hist0.size(); i++)
            chk($sformatf("rx_byte_%0d", i), int'(rx_hist0[i]), 'hF0 + i);
        chk("done_with_last_rx", t_done[0], t_rx[0]);
        for (int i = 0; i < 100 && grants.size() < 2; i++) @(posedge clk);
        bound_ok("wait_grant1", grants.size() >= 2);
        chk("first_grant", grants[0], 0);
        chk("second_grant", grants[1], 1);
        chk("gap_to_next_grant", t_rr[1] - t_done[0], GAP + 1);
        pend0.push_back(1);
        for (int i = 0; i < 400 && done_cnt[1] < 1; i++) @(posedge clk);
        bound_ok("wait_done1", done_cnt[1] >= 1);
        chk("held_strobe_rx", rx_cnt[1], 2);
        chk("held_strobe_done", done_cnt[1], 1);
        for (int i = 0; i < 400 && done_cnt[0] < 2; i++) @(posedge clk);
        bound_ok("wait_done0_again", done_cnt[0] >= 2);
        chk("third_grant", grants[2], 0);
        slave_hold = 1;

        // zero-length request
        wait_idle("idle_before_zero");
        hi0 = i2c_hi;
        pend1.push_back(0);
        for (int i = 0; i < 100 && done_cnt[1] < 2; i++) @(posedge clk);
        bound_ok("wait_zero_done", done_cnt[1] >= 2);
        chk("zero_done_latency", t_done[1] - t_rr[1], 1);
        chk("zero_busy_low", int'(done_busy[1]), 0);
        chk("zero_no_i2c_ready", i2c_hi - hi0, 0);

        // one byte then stall -> timeout
        wait_idle("idle_before_timeout");
        slave_limit = 1;
        rc = rx_cnt[1]; dc = done_cnt[1];
        pend1.push_back(3);
        for (int i = 0; i < TO + 200 && tmo_cnt[1] < 1; i++) @(posedge clk);
        bound_ok("wait_timeout", tmo_cnt[1] >= 1);
        chk("timeout_latency", t_tmo[1] - t_rx[1], TO);
        chk("timeout_rx_count", rx_cnt[1] - rc, 1);
        chk("timeout_no_done", done_cnt[1] - dc, 0);
        chk("timeout_ready_low", int'(tmo_i2c[1]), 0);
        slave_limit = 15;

        // reset during the 4th byte of a 7-byte transfer
        wait_idle("idle_before_reset");
        slave_hold = 4; slave_base = 8'h30;
        rc = rx_cnt[0];
        pend0.push_back(7);
        for (int i = 0; i < 400 && rx_cnt[0] < rc + 3; i++) @(posedge clk);
        bound_ok("wait_third_byte", rx_cnt[0] >= rc + 3);
        for (int i = 0; i < 20 && i2c_data_valid; i++) @(posedge clk);
        for (int i = 0; i < 20 && !i2c_data_valid; i++) @(posedge clk);
        bound_ok("wait_fourth_strobe", i2c_data_valid);
        #2;
        dc = done_cnt[0] + done_cnt[1]; tc = tmo_cnt[0] + tmo_cnt[1];
        rst_n = 1'b0;
        #1;
        chk("async_reset_ctrl", int'({req_ready, rx_valid, done, timeout_err, busy, i2c_ready}), 0);
        chk("async_reset_rx_data", int'(rx_data), 0);
        chk("async_reset_bytes", int'(i2c_data_bytes), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        chk("reset_no_done", done_cnt[0] + done_cnt[1] - dc, 0);
        chk("reset_no_timeout", tmo_cnt[0] + tmo_cnt[1] - tc, 0);
        slave_hold = 1;
        rc = rx_cnt[0]; dc = done_cnt[0];
        pend0.push_back(2);
        for (int i = 0; i < 200 && done_cnt[0] <= dc; i++) @(posedge clk);
        bound_ok("wait_post_reset_done", done_cnt[0] > dc);
        chk("post_reset_rx_count", rx_cnt[0] - rc, 2);
        chk("post_reset_done_align", t_done[0], t_rx[0]);

        // randomised traffic with strobe noise outside transfers
        noise_en = 1; req_rand = 1;
        for (int k = 0; k < 120; k++) begin
            repeat ($urandom_range(0, 40)) @(posedge clk);
            if ($urandom_range(0, 1) == 0) pend0.push_back(int'($urandom_range(0, 15)));
            else pend1.push_back(int'($urandom_range(0, 15)));
            slave_hold = int'($urandom_range(1, 4));
            slave_gap = int'($urandom_range(1, 3));
            slave_limit = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : 15;
        end
        for (int i = 0; i < 40000 && (pend0.size() > 0 || pend1.size() > 0 ||
                                      req_valid != 2'b00 || busy); i++) @(posedge clk);
        bound_ok("random_drain", pend0.size() == 0 && pend1.size() == 0 &&
                                 req_valid == 2'b00 && !busy);
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mis_n);
        $finish;
    end

endmodule

// File: doc/i2c_rx_arbiter.md
I2C_RX_ARBITER -- requirements
Module: i2c_rx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 4096: number of XFER cycles allowed without a new byte before the transfer is aborted.
REQ-002 Parameter GAP_CYC, default 16: number of idle cycles enforced between transfers (bus free time).
REQ-003 clk  in  1  single clock; all logic is posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  2  per-requester read request; bit n belongs to requester n.
REQ-006 req_bytes0 / req_bytes1  in  4 each  byte count requested by requester 0 / 1.
REQ-007 req_ready  out  2  one-hot, one-cycle pulse: request accepted.
REQ-008 rx_data  out  8  received byte, valid only while rx_valid is non-zero.
REQ-009 rx_valid  out  2  one-hot, one-cycle pulse: rx_data belongs to that requester.
REQ-010 done  out  2  one-hot, one-cycle pulse: all requested bytes delivered.
REQ-011 timeout_err  out  2  one-hot, one-cycle pulse: transfer aborted by timeout.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 i2c_ready  out  1  start/enable to i2c_receive; held high for the whole transfer.
REQ-014 i2c_data_bytes  out  4  byte count driven to i2c_receive; stable while i2c_ready is high.
REQ-015 i2c_data  in  8  byte from i2c_receive.
REQ-016 i2c_data_valid  in  1  byte strobe from i2c_receive; may stay high for more than one cycle.

Function
REQ-017 The FSM SHALL have the states IDLE, XFER and GAP and SHALL be fully registered.
REQ-018 IDLE: when any req_valid bit is high, grant one requester, latch its req_bytes, pulse req_ready[grant] on the next cycle and enter XFER.
REQ-019 Arbitration SHALL be round-robin: when both requests are high, grant the index that is not last_grant; a single request always wins.
REQ-020 A requester SHALL hold req_valid and req_bytes until it sees req_ready; the block SHALL sample them only in IDLE.
REQ-021 A request with req_bytes==0 SHALL pulse req_ready, then pulse done on the following cycle, leave i2c_ready low, and return to IDLE without entering GAP.
REQ-022 XFER: i2c_ready=1 and i2c_data_bytes=latched count.
REQ-023 Each rising edge of i2c_data_valid (0->1, detected against a registered copy) SHALL count exactly one byte.
REQ-024 For each counted byte, rx_data SHALL equal i2c_data as sampled on the edge cycle, and rx_valid[grant] SHALL pulse one cycle after the edge (latency 1).
REQ-025 When the 4-bit byte count equals the latched count, the block SHALL pulse done[grant] in the same cycle as the final rx_valid, drop i2c_ready on the next cycle and enter GAP.
REQ-026 The timeout counter SHALL clear on entering XFER and on every counted byte; at TIMEOUT_CYC-1 it SHALL pulse timeout_err[grant], drop i2c_ready and enter GAP with no done pulse.
REQ-027 If a byte edge and the timeout terminal count fall in the same cycle, the byte SHALL win: the byte is counted and the counter clears.
REQ-028 GAP SHALL last exactly GAP_CYC cycles with i2c_ready=0, then return to IDLE; requests raised during XFER or GAP SHALL wait.
REQ-029 last_grant SHALL update on every grant, including grants with req_bytes==0.
REQ-030 Strobes from i2c_data_valid that arrive in IDLE or GAP SHALL be ignored.

Reset
REQ-031 On reset, all outputs SHALL be 0 (rx_data=8'h00, i2c_data_bytes=4'h0), the FSM SHALL enter IDLE, last_grant SHALL be 1, and all counters and the edge-detect register SHALL be 0.
REQ-032 Reset asserted mid-transfer SHALL drop i2c_ready immediately (asynchronously) and discard the transfer, with no done or timeout_err pulse.

Structure
REQ-033 The state enum and the default values of TIMEOUT_CYC and GAP_CYC SHALL live in the shared package i2c_pkg.
REQ-034 Arbitration SHALL be a sub-module i2c_rr_arb2 (inputs: req[1:0], last_grant; output: one-hot grant), instantiated once.

Verification
REQ-035 Requester 0 asks for 7 bytes; model streams F0..F6 -> rx_valid[0] pulses 7 times with F0..F6, done[0] pulses with the 7th byte, i2c_ready is low for 16 cycles afterwards.
REQ-036 Both requesters raise req_valid in the same cycle right after reset -> requester 0 is granted first, requester 1 is granted immediately after the GAP, then requester 0 again if it re-requests.
REQ-037 Requester 1 asks for 3 bytes; model sends 1 byte, then stalls -> timeout_err[1] pulses TIMEOUT_CYC cycles after the byte, done stays 0, i2c_ready drops.
REQ-038 The model holds i2c_data_valid high for 4 cycles per byte while 2 bytes are requested -> exactly 2 rx_valid pulses and 1 done.
REQ-039 Request with req_bytes=0 -> req_ready then done on consecutive cycles, i2c_ready never asserts, busy returns low within 2 cycles.
REQ-040 rst_n pulsed low during the 4th byte of a 7-byte transfer -> all outputs are 0 at once, and the next request is granted normally with a fresh byte count.
